instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
// - Prefetch stage directly upstream of the CPU core's instruction register.
// - Streams sequential word reads from the synchronous instruction RAM (1-cycle read latency).
// - Queues returned words with their PCs and presents the head to the core with a valid flag.
// - Core pops the head when it loads IR.
// - Branch/reset redirects flush the queue and restart fetch at a new PC.
// PARAMETERS
// - ADDR_W  11  word-address width; matches CPU PC and RAM address
// - DATA_W  32  instruction width
// - DEPTH   4   queue entries; power of two, >= 2
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous, active-low reset
// - redirect     in   1       flush queue, restart fetch at redirect_pc
// - redirect_pc  in   ADDR_W  new fetch PC; sampled when redirect=1
// - consume      in   1       core loads IR; pops head when instr_valid=1
// - instr        out  DATA_W  head instruction; 0 when instr_valid=0
// - instr_pc     out  ADDR_W  PC of head instruction; 0 when instr_valid=0
// - instr_valid  out  1       queue non-empty
// - mem_rd_en    out  1       RAM read strobe
// - mem_addr     out  ADDR_W  RAM word address
// - mem_rdata    in   DATA_W  RAM data; valid the cycle after mem_rd_en
// BEHAVIOUR
// - State machine: IDLE, RUN.
//   - rst_n=0 -> IDLE. Queue empty, fetch_pc=0, inflight=0, all outputs 0.
//   - IDLE: no reads. mem_rd_en=0, mem_addr=fetch_pc.
//   - redirect=1 in any state -> RUN.
// - Redirect cycle:
//   - Queue count forced to 0.
//   - Any word returning this cycle is discarded.
//   - mem_rd_en=1, mem_addr=redirect_pc (combinational bypass).
//   - fetch_pc <= redirect_pc+1; inflight <= 1.
// - RUN, no redirect:
//   - Issue when (count + inflight) < DEPTH.
//   - On issue: mem_rd_en=1, mem_addr=fetch_pc, fetch_pc <= fetch_pc+1.
//   - inflight <= mem_rd_en.
// - Capture: if inflight=1 and no redirect, push {mem_rdata, pc_of_read} at the clock edge.
// - PC arithmetic is modulo 2^ADDR_W. 2047+1 wraps to 0 at ADDR_W=11; no error.
// - Pop: consume=1 with instr_valid=1 -> head advances at the edge. consume with instr_valid=0 is ignored.
// - Simultaneous push and pop: count unchanged, both take effect.
// - Overflow cannot occur: credit includes inflight. Push into a full queue is a design bug; bench asserts on it.
// - Redirect with consume in the same cycle: redirect wins, pop discarded.
// - Latency:
//   - Redirect at cycle N -> instr_valid=1, instr_pc=redirect_pc in cycle N+2.
//   - Steady state: 1 instr/cycle while consume=1.
// - Reset mid-stream: async clear to reset state; any read in flight is ignored after release.
// CONFIGURATION
// - FETCH_STATS_EN defined: adds outputs fetch_count[31:0] and flush_count[15:0].
//   - fetch_count: +1 per accepted push.
//   - flush_count: +1 per redirect that discards >= 1 queued or inflight word.
//   - Both reset to 0, saturate at all-ones.
// - FETCH_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset then idle 5 cycles -> mem_rd_en=0, instr_valid=0, instr=0, instr_pc=0 throughout.
// - redirect_pc=0x010 at cycle N, consume held 1 -> instr_pc 0x010,0x011,0x012... from N+2, one per cycle.
// - consume=0 after redirect to 0x020 -> exactly DEPTH=4 reads (0x020-0x023), then mem_rd_en=0.
//   Resume consume -> in-order 0x020..0x023, then fetch resumes at 0x024.
// - Queue holds 3 entries, read inflight, redirect to 0x100 with consume=1
//   -> stale word dropped; first valid instr_pc=0x100 at N+2; no stale PC ever appears.
// - redirect_pc=0x7FE -> instr_pc 0x7FE, 0x7FF, 0x000, 0x001.
// - rst_n low mid-stream (count=2) -> instr_valid=0 and mem_rd_en=0 asynchronously; IDLE after release.
//   With FETCH_STATS_EN: fetch_count and flush_count reset to 0; flush_count=1 after the flushing redirect.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: streams sequential reads from a 1-cycle-latency RAM and
// presents the head word to the core. Optional statistics counters under FETCH_STATS_EN.
module instr_fetch_queue #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              consume,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              state_dbg
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] fetch_pc, inflight_pc;
  logic              inflight;
  logic              issue, push, pop;

  // Handshake: the head is offered while instr_valid=1; consume=1 in such a cycle
  // pops it at the edge. consume while instr_valid=0 has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect) state_nxt = RUN;
  end

  // Credit includes the in-flight read so a returning word always finds a free slot.
  always_comb begin
    issue    = 1'b0;
    mem_addr = fetch_pc;
    if (redirect) begin
      issue    = 1'b1;
      mem_addr = redirect_pc;
    end else if (state == RUN && (count + CW'(inflight)) < CW'(DEPTH)) begin
      issue = 1'b1;
    end
    mem_rd_en = issue;
  end

  assign state_dbg   = (state == RUN);
  assign push        = inflight & ~redirect;
  assign instr_valid = (count != '0);
  assign pop         = consume & instr_valid & ~redirect;
  assign instr       = instr_valid ? data_q[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_pc    <= redirect_pc + ADDR_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= redirect_pc;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef FETCH_STATS_EN
  // A redirect only counts as a flush when it throws away a queued or returning word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if (redirect && (count != '0 || inflight) && flush_count != '1)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
